// File: rtl/bus_response_merger.sv
// Purpose: round-robin merge of num_buses source buses onto one registered output bus.
// Latency: a word accepted on edge N is presented on data_out right after edge N.
// Backpressure: while data_out is held and data_ready is low, every bus_ready stays 0 and sources keep their requests.
module bus_response_merger #(
  parameter int num_buses     = 2,
  parameter int num_buses_log = 1,
  parameter int bus_width     = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [num_buses*bus_width-1:0] bus_in,
  input  logic [num_buses-1:0]           bus_valid,
  output logic [num_buses-1:0]           bus_ready,
  output logic [bus_width-1:0]           data_out,
  output logic                           data_valid,
  input  logic                           data_ready,
  output logic [num_buses_log-1:0]       select_out
);

  // Index of the most recently loaded source; the search starts just after it.
  logic [num_buses_log-1:0] last_grant;

  logic                     win_found;
  logic [num_buses_log-1:0] win_idx;
  logic [bus_width-1:0]     win_data;
  logic [num_buses-1:0]     win_onehot;
  logic                     can_load;
  logic                     load;
  int                       cand;

  // Round-robin search: first requesting slot after last_grant, wrapping.
  // Candidates are always reduced modulo num_buses, so unused index codes
  // can never win when num_buses is not a power of two.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_data   = '0;
    win_onehot = '0;
    cand       = 0;
    for (int k = 1; k <= num_buses; k++) begin
      cand = (int'(last_grant) + k) % num_buses;
      if (!win_found && bus_valid[cand]) begin
        win_found        = 1'b1;
        win_idx          = cand[num_buses_log-1:0];
        win_data         = bus_in[cand*bus_width +: bus_width];
        win_onehot[cand] = 1'b1;
      end
    end
  end

  // The output register may take a new word when empty or draining this cycle.
  // Held in reset, nothing is accepted so no source believes it was consumed.
  assign can_load  = rst_n && (!data_valid || data_ready);
  assign load      = can_load && win_found;
  assign bus_ready = load ? win_onehot : '0;

  // Output stage and arbitration pointer; the pointer only moves on a real load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
      data_out   <= '0;
      select_out <= '0;
      last_grant <= num_buses_log'(num_buses - 1);
    end else if (load) begin
      data_valid <= 1'b1;
      data_out   <= win_data;
      select_out <= win_idx;
      last_grant <= win_idx;
    end else if (data_ready) begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_response_merger.sv
module tb_bus_response_merger;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] s0, s1;
  logic [511:0] bus_in;
  logic [1:0]   bus_valid;
  logic [1:0]   bus_ready;
  logic [255:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic [0:0]   select_out;

  logic [47:0]  b3_in;
  logic [2:0]   b3_valid;
  logic [2:0]   b3_ready;
  logic [15:0]  d3_out;
  logic         d3_valid;
  logic         d3_ready;
  logic [1:0]   sel3_out;

  typedef struct {
    logic [255:0] d;
    logic [0:0]   s;
  } exp_t;
  typedef struct {
    logic [15:0] d;
    logic [1:0]  s;
  } exp3_t;

  exp_t  sbq[$];
  exp3_t q3[$];
  exp_t  e;
  exp3_t e3;

  int n_assert = 0;
  int n_fail   = 0;

  assign bus_in = {s1, s0};

  always #5 clk = ~clk;

  bus_response_merger #(.num_buses(2), .num_buses_log(1), .bus_width(256)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .select_out(select_out)
  );

  bus_response_merger #(.num_buses(3), .num_buses_log(2), .bus_width(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus_in(b3_in), .bus_valid(b3_valid),
    .bus_ready(b3_ready), .data_out(d3_out), .data_valid(d3_valid),
    .data_ready(d3_ready), .select_out(sel3_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_valid = 2'b00;
    b3_valid  = 3'b000;
    rst_n     = 1'b0;
    #2;
    rst_n     = 1'b1;
    #1;
  endtask

  task automatic idle();
    bus_valid  = 2'b00;
    data_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1;
    n_assert++;
    if (data_valid !== 1'b0 || data_out !== '0 || select_out !== 1'b0 || bus_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_init: valid=%b out=%h sel=%b rdy=%b, need 0/0/0/00", data_valid, data_out, select_out, bus_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    // load one word, then assert reset while it is held
    s0 = 256'h33; bus_valid = 2'b01; data_ready = 1'b1;
    tick();
    n_assert++;
    if (data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_preload_valid: got %b need 1", data_valid);
    end
    data_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (data_valid !== 1'b0 || data_out !== '0 || select_out !== 1'b0 || bus_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b out=%h sel=%b rdy=%b, need 0/0/0/00", data_valid, data_out, select_out, bus_ready);
    end
    rst_n = 1'b1;
    s0 = {32{8'hAA}}; bus_valid = 2'b01; data_ready = 1'b1;
    #1;
    n_assert++;
    if (bus_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_after_rdy: got %b need 01", bus_ready);
    end
    sbq.push_back('{d: {32{8'hAA}}, s: 1'b0});
    tick();
    n_assert++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL reset_after_sb: scoreboard empty");
    end else begin
      e = sbq.pop_front();
      if (data_valid !== 1'b1 || data_out !== e.d || select_out !== e.s) begin
        n_fail++;
        $display("FAIL reset_after_load: valid=%b out=%h sel=%b need 1/%h/%b", data_valid, data_out, select_out, e.d, e.s);
      end
    end
    idle();
  endtask

  task automatic test_alternation();
    logic [1:0] exp_rdy;
    do_reset();
    s0 = 256'h1; s1 = 256'h2; bus_valid = 2'b11; data_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_assert++;
      if (bus_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL alt_rdy[%0d]: got %b need %b", i, bus_ready, exp_rdy);
      end
      sbq.push_back('{d: (i % 2 == 0) ? 256'h1 : 256'h2, s: (i % 2 == 0) ? 1'b0 : 1'b1});
      tick();
      e = sbq.pop_front();
      n_assert++;
      if (data_valid !== 1'b1 || data_out !== e.d || select_out !== e.s) begin
        n_fail++;
        $display("FAIL alt_out[%0d]: valid=%b out=%h sel=%b need 1/%h/%b", i, data_valid, data_out, select_out, e.d, e.s);
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    s1 = 256'h5; bus_valid = 2'b10; data_ready = 1'b1;
    sbq.push_back('{d: 256'h5, s: 1'b1});
    tick();
    e = sbq.pop_front();
    n_assert++;
    if (data_out !== e.d || select_out !== e.s || data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_load: out=%h sel=%b valid=%b need %h/%b/1", data_out, select_out, data_valid, e.d, e.s);
    end
    s0 = 256'h7; bus_valid = 2'b11; data_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_assert++;
      if (bus_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_rdy[%0d]: got %b need 00", i, bus_ready);
      end
      tick();
      n_assert++;
      if (data_out !== 256'h5 || select_out !== 1'b1 || data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out=%h sel=%b valid=%b need 5/1/1", i, data_out, select_out, data_valid);
      end
    end
    data_ready = 1'b1;
    #1;
    n_assert++;
    if (bus_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release_rdy: got %b need 01", bus_ready);
    end
    sbq.push_back('{d: 256'h7, s: 1'b0});
    tick();
    e = sbq.pop_front();
    n_assert++;
    if (data_out !== e.d || select_out !== e.s || data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_out: out=%h sel=%b valid=%b need %h/%b/1", data_out, select_out, data_valid, e.d, e.s);
    end
    idle();
  endtask

  task automatic test_single_stream();
    do_reset();
    bus_valid = 2'b10; data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s1 = 256'h100 + 256'(i);
      #1;
      n_assert++;
      if (bus_ready !== 2'b10) begin
        n_fail++;
        $display("FAIL stream_rdy[%0d]: got %b need 10", i, bus_ready);
      end
      sbq.push_back('{d: 256'h100 + 256'(i), s: 1'b1});
      tick();
      e = sbq.pop_front();
      n_assert++;
      if (data_out !== e.d || select_out !== e.s || data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_out[%0d]: out=%h sel=%b valid=%b need %h/%b/1", i, data_out, select_out, data_valid, e.d, e.s);
      end
    end
    s0 = 256'h55; bus_valid = 2'b11;
    #1;
    n_assert++;
    if (bus_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL stream_prio_rdy: got %b need 01", bus_ready);
    end
    sbq.push_back('{d: 256'h55, s: 1'b0});
    tick();
    e = sbq.pop_front();
    n_assert++;
    if (data_out !== e.d || select_out !== e.s) begin
      n_fail++;
      $display("FAIL stream_prio_out: out=%h sel=%b need %h/%b", data_out, select_out, e.d, e.s);
    end
    idle();
  endtask

  task automatic test_idle_drain();
    do_reset();
    s0 = 256'h9; bus_valid = 2'b01; data_ready = 1'b1;
    sbq.push_back('{d: 256'h9, s: 1'b0});
    tick();
    e = sbq.pop_front();
    n_assert++;
    if (data_out !== e.d || select_out !== e.s || data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_load: out=%h sel=%b valid=%b need %h/%b/1", data_out, select_out, data_valid, e.d, e.s);
    end
    bus_valid = 2'b00;
    #1;
    n_assert++;
    if (bus_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL drain_rdy: got %b need 00", bus_ready);
    end
    tick();
    n_assert++;
    if (data_valid !== 1'b0 || data_out !== 256'h9 || select_out !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_hold: valid=%b out=%h sel=%b need 0/9/0", data_valid, data_out, select_out);
    end
  endtask

  task automatic test_sweep3();
    logic [2:0] exp_rdy;
    do_reset();
    b3_in = {16'h0012, 16'h0011, 16'h0010};
    b3_valid = 3'b111; d3_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_rdy = 3'b001 << (i % 3);
      n_assert++;
      if (b3_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL sweep_rdy[%0d]: got %b need %b", i, b3_ready, exp_rdy);
      end
      q3.push_back('{d: 16'h0010 + 16'(i % 3), s: 2'(i % 3)});
      tick();
      e3 = q3.pop_front();
      n_assert++;
      if (d3_out !== e3.d || sel3_out !== e3.s || d3_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_out[%0d]: out=%h sel=%0d valid=%b need %h/%0d/1", i, d3_out, sel3_out, d3_valid, e3.d, e3.s);
      end
    end
    b3_valid = 3'b000;
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    s0         = '0;
    s1         = '0;
    bus_valid  = 2'b00;
    data_ready = 1'b0;
    b3_in      = '0;
    b3_valid   = 3'b000;
    d3_ready   = 1'b1;
    test_reset();
    test_alternation();
    test_backpressure();
    test_single_stream();
    test_idle_drain();
    test_sweep3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
